// File: rtl/nn_host_pkg.sv
// Shared types and constants for the NN accelerator host controller.
package nn_host_pkg;

  // Controller sequence states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    POLL   = 3'd3,
    READ   = 3'd4,
    CLEAR  = 3'd5,
    RESULT = 3'd6
  } state_t;

  // Register-file addresses of the control/status words.
  localparam logic [3:0] ADDR_START = 4'd10;
  localparam logic [3:0] ADDR_DONE  = 4'd11;

  // Width of one probability value.
  localparam int PROB_W = 16;

  // Unsigned strict comparison; equal values do not win, so ties keep the
  // earlier (lower) index.
  function automatic logic prob_gt(input logic [PROB_W-1:0] a,
                                   input logic [PROB_W-1:0] b);
    return (a > b);
  endfunction

endpackage

// File: rtl/nn_host_ctrl_if.sv
// Register-file slave bus: write strobe, address, write data and
// zero-latency (combinational) read data.
interface nn_host_ctrl_if;
  logic        W;
  logic [3:0]  Addr;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;

  // Host side drives the strobe/address/data and consumes read data.
  modport master (output W, output Addr, output Write_Data, input Read_Data);
  // Register file side.
  modport slave  (input W, input Addr, input Write_Data, output Read_Data);
endinterface

// File: rtl/nn_argmax_acc.sv
// Running argmax over a stream of (index, value) pairs.
module nn_argmax_acc
  import nn_host_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [PROB_W-1:0] i_value,
  output logic [PROB_W-1:0] o_best,
  output logic [IDX_W-1:0]  o_bestidx
);

  logic [PROB_W-1:0] r_best;
  logic [IDX_W-1:0]  r_bestidx;
  logic              w_load;

  // Index 0 always seeds the max; later indices replace it only when larger.
  always_comb begin
    w_load = 1'b0;
    if (i_valid) begin
      w_load = (i_idx == '0) || prob_gt(i_value, r_best);
    end else begin
      w_load = 1'b0;
    end
  end

  // Running max/index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best    <= '0;
      r_bestidx <= '0;
    end else if (i_clear) begin
      r_best    <= '0;
      r_bestidx <= '0;
    end else if (w_load) begin
      r_best    <= i_value;
      r_bestidx <= i_idx;
    end else begin
      r_best    <= r_best;
      r_bestidx <= r_bestidx;
    end
  end

  assign o_best    = r_best;
  assign o_bestidx = r_bestidx;

endmodule

// File: rtl/nn_host_ctrl.sv
// Host controller: starts the NN accelerator, waits for completion, reads
// the class probabilities and reports the winning digit.
module nn_host_ctrl
  import nn_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NUM_CLASSES    = 10
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Go,
  nn_host_ctrl_if.master       bus,
  output logic                 Busy,
  output logic                 Result_Valid,
  output logic [3:0]           Digit,
  output logic [PROB_W-1:0]    Max_Prob,
  output logic                 Error
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]     LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic [3:0]        r_idx;

  logic              w_w;
  logic [3:0]        w_addr;
  logic [31:0]       w_wdata;
  logic              w_done;
  logic [PROB_W-1:0] w_prob;
  logic              w_tmo;
  logic [CNT_W-1:0]  w_tmo_inc;
  logic              w_acc_clear;
  logic              w_acc_valid;
  logic [PROB_W-1:0] w_best;
  logic [3:0]        w_bestidx;
  logic              w_unused_hi;

  assign w_done      = bus.Read_Data[0];
  assign w_prob      = bus.Read_Data[PROB_W-1:0];
  assign w_unused_hi = ^bus.Read_Data[31:PROB_W];
  assign w_tmo       = (r_tmo_cnt >= CNT_LAST);
  assign w_tmo_inc   = (r_tmo_cnt == CNT_MAX) ? r_tmo_cnt : (r_tmo_cnt + CNT_W'(1));
  assign w_acc_clear = (r_state == POLL) && w_done;
  assign w_acc_valid = (r_state == READ);

  // Bus outputs decoded from state so W drops the instant reset hits.
  always_comb begin
    w_w     = 1'b0;
    w_addr  = 4'd0;
    w_wdata = 32'd0;
    case (r_state)
      ARM, POLL: begin
        w_addr = ADDR_DONE;
      end
      START: begin
        w_w     = 1'b1;
        w_addr  = ADDR_START;
        w_wdata = 32'd1;
      end
      READ: begin
        w_addr = r_idx;
      end
      CLEAR: begin
        w_w     = 1'b1;
        w_addr  = ADDR_START;
        w_wdata = 32'd0;
      end
      default: begin
        w_w     = 1'b0;
        w_addr  = 4'd0;
        w_wdata = 32'd0;
      end
    endcase
  end

  assign bus.W          = w_w;
  assign bus.Addr       = w_addr;
  assign bus.Write_Data = w_wdata;

  nn_argmax_acc #(.IDX_W(4)) u_acc (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_clear   (w_acc_clear),
    .i_valid   (w_acc_valid),
    .i_idx     (r_idx),
    .i_value   (w_prob),
    .o_best    (w_best),
    .o_bestidx (w_bestidx)
  );

  // Main sequencer with registered status/result outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_tmo_cnt    <= '0;
      r_idx        <= 4'd0;
      Busy         <= 1'b0;
      Result_Valid <= 1'b0;
      Digit        <= 4'd0;
      Max_Prob     <= '0;
      Error        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Go) begin
            r_state   <= ARM;
            Busy      <= 1'b1;
            Error     <= 1'b0;
            r_tmo_cnt <= '0;
          end
        end
        ARM: begin
          // A stale Done from a previous run must clear before starting.
          if (!w_done) begin
            r_state   <= START;
            r_tmo_cnt <= '0;
          end else if (w_tmo) begin
            r_state <= CLEAR;
            Error   <= 1'b1;
          end else begin
            r_tmo_cnt <= w_tmo_inc;
          end
        end
        START: begin
          r_state   <= POLL;
          r_tmo_cnt <= '0;
        end
        POLL: begin
          if (w_done) begin
            r_state <= READ;
            r_idx   <= 4'd0;
          end else if (w_tmo) begin
            r_state <= CLEAR;
            Error   <= 1'b1;
          end else begin
            r_tmo_cnt <= w_tmo_inc;
          end
        end
        READ: begin
          if (r_idx == LAST_IDX) begin
            r_state <= CLEAR;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        CLEAR: begin
          // Error stays clear on the normal path, so it selects the exit.
          if (Error) begin
            r_state <= IDLE;
            Busy    <= 1'b0;
          end else begin
            r_state      <= RESULT;
            Digit        <= w_bestidx;
            Max_Prob     <= w_best;
            Result_Valid <= 1'b1;
          end
        end
        RESULT: begin
          r_state      <= IDLE;
          Busy         <= 1'b0;
          Result_Valid <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          Busy         <= 1'b0;
          Result_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
